booth_mult8_issue_ctrl: RTL and testbench

Upstream issue/collect controller for the 8-bit pipelined Booth multiplier core. It accepts operand requests on a valid/ready stream and holds the operands stable at the core. It pulses the core's start for one cycle, waits for the core's done pulse, then captures the product into an output register with valid/ready backpressure. It enforces one outstanding operation and carries a user tag through with each result.

---
 rtl/booth_mult8_issue_ctrl.sv | 118 +++++++++++
 tb/tb_booth_mult8_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult8_issue_ctrl.sv
// Issue/collect controller for the pipelined Booth multiplier core: one operation in flight, tag carried through.
// Optional core_done watchdog enabled by defining BOOTH_ISSUE_TIMEOUT_EN.
module booth_mult8_issue_ctrl #(
    parameter int WIDTH       = 8,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mcand,
    input  logic [WIDTH-1:0]     in_mplier,
    input  logic [1:0]           in_sign_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 core_start,
    output logic [WIDTH-1:0]     core_multiplicand,
    output logic [WIDTH-1:0]     core_multiplier,
    output logic [1:0]           core_sign_mode,
    input  logic [2*WIDTH-1:0]   core_product,
    input  logic                 core_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state;
    logic   accept;

    // HOLD forwards out_ready so a retiring result and a new request share one edge.
    assign in_ready = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef BOOTH_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = |TIMEOUT_CYC;
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            core_start        <= 1'b0;
            core_multiplicand <= '0;
            core_multiplier   <= '0;
            core_sign_mode    <= '0;
            out_valid         <= 1'b0;
            out_product       <= '0;
            out_tag           <= '0;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
            out_err           <= 1'b0;
            wait_cnt          <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) state <= S_ISSUE;
                end
                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (core_done) begin
                        out_product <= core_product;
                        out_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end
`ifdef BOOTH_ISSUE_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        out_product <= '0;
                        out_valid   <= 1'b1;
                        out_err     <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef BOOTH_ISSUE_TIMEOUT_EN
                        out_err   <= 1'b0;
`endif
                        state     <= in_valid ? S_ISSUE : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                core_multiplicand <= in_mcand;
                core_multiplier   <= in_mplier;
                core_sign_mode    <= in_sign_mode;
                out_tag           <= in_tag;
                core_start        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult8_issue_ctrl.sv
// Self-checking bench for booth_mult8_issue_ctrl with a behavioural 9-cycle Booth core model.
// Timeout scenario is compiled in when BOOTH_ISSUE_TIMEOUT_EN is defined.
module tb_booth_mult8_issue_ctrl;

    localparam int WIDTH       = 8;
    localparam int TAG_W       = 4;
    localparam int TIMEOUT_CYC = 32;
    localparam int LAT         = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_mcand;
    logic [WIDTH-1:0]     in_mplier;
    logic [1:0]           in_sign_mode;
    logic [TAG_W-1:0]     in_tag;
    logic                 core_start;
    logic [WIDTH-1:0]     core_multiplicand;
    logic [WIDTH-1:0]     core_multiplier;
    logic [1:0]           core_sign_mode;
    logic [2*WIDTH-1:0]   core_product;
    logic                 core_done;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_err;

    int total = 0;
    int bad   = 0;

    booth_mult8_issue_ctrl #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mcand(in_mcand),
        .in_mplier(in_mplier),
        .in_sign_mode(in_sign_mode),
        .in_tag(in_tag),
        .core_start(core_start),
        .core_multiplicand(core_multiplicand),
        .core_multiplier(core_multiplier),
        .core_sign_mode(core_sign_mode),
        .core_product(core_product),
        .core_done(core_done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_product(out_product),
        .out_tag(out_tag),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: operands widened to int according to the sign mode, product truncated.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        int sa, sb, p;
        if (m[1]) sa = int'($signed(a)); else sa = int'(a);
        if (m[0]) sb = int'($signed(b)); else sb = int'(b);
        p = sa * sb;
        return p[15:0];
    endfunction

    // Core model: start sampled at an edge gives core_done during the cycle after the 8th following edge.
    logic        done_en = 1'b1;
    logic [8:0]  start_sr = '0;
    logic [15:0] core_prod_r = '0;
    always @(posedge clk) begin
        start_sr <= {start_sr[7:0], core_start & done_en};
        if (core_start) core_prod_r <= ref_mul(core_multiplicand, core_multiplier, core_sign_mode);
    end
    assign core_done    = start_sr[8];
    assign core_product = core_done ? core_prod_r : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(output int n, output int starts);
        n = 0;
        starts = (core_start === 1'b1) ? 1 : 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (core_start === 1'b1) starts++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({out_valid, out_err, core_start, in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_ctrl: valid/err/start/ready=%b expected 0001", {out_valid, out_err, core_start, in_ready});
        end
        total++;
        if ({out_product, out_tag} !== '0) begin
            bad++;
            $display("FAIL reset_out: product=%h tag=%h expected 0", out_product, out_tag);
        end
        total++;
        if ({core_multiplicand, core_multiplier, core_sign_mode} !== '0) begin
            bad++;
            $display("FAIL reset_core_regs: %h %h %b expected 0", core_multiplicand, core_multiplier, core_sign_mode);
        end
    endtask

    task automatic test_arith();
        logic [7:0]  da[3] = '{8'hFD, 8'hFF, 8'hFF};
        logic [7:0]  db[3] = '{8'h05, 8'hFF, 8'h02};
        logic [1:0]  dm[3] = '{2'b11, 2'b00, 2'b10};
        logic [15:0] dp[3] = '{16'hFFF1, 16'hFE01, 16'hFFFE};
        logic [7:0]  a, b;
        logic [1:0]  m;
        logic [3:0]  t;
        logic [15:0] exp_p;
        int n, starts;
        out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            if (i < 3) begin
                a = da[i]; b = db[i]; m = dm[i]; t = 4'(i + 3); exp_p = dp[i];
            end else begin
                a = 8'($urandom); b = 8'($urandom); m = 2'($urandom_range(0, 3)); t = 4'($urandom);
                exp_p = ref_mul(a, b, m);
            end
            in_mcand = a; in_mplier = b; in_sign_mode = m; in_tag = t; in_valid = 1'b1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL arith_ready[%0d]: in_ready=%b expected 1", i, in_ready);
            end
            tick();
            in_valid = 1'b0;
            in_mcand = 8'($urandom); in_mplier = 8'($urandom); in_sign_mode = 2'($urandom); in_tag = 4'($urandom);
            total++;
            if ({core_multiplicand, core_multiplier, core_sign_mode} !== {a, b, m}) begin
                bad++;
                $display("FAIL arith_core_ops[%0d]: %h %h %b expected %h %h %b", i,
                         core_multiplicand, core_multiplier, core_sign_mode, a, b, m);
            end
            wait_result(n, starts);
            total++;
            if (n !== LAT || starts !== 1) begin
                bad++;
                $display("FAIL arith_latency[%0d]: cycles=%0d starts=%0d expected %0d and 1", i, n, starts, LAT);
            end
            total++;
            if (out_product !== exp_p || out_tag !== t || out_err !== 1'b0) begin
                bad++;
                $display("FAIL arith_result[%0d]: product=%h tag=%h err=%b expected %h %h 0", i,
                         out_product, out_tag, out_err, exp_p, t);
            end
            tick();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL arith_retire[%0d]: valid=%b ready=%b expected 0 1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_p;
        int n, starts, errs;
        exp_p = ref_mul(8'h12, 8'h34, 2'b00);
        out_ready = 1'b0;
        in_mcand = 8'h12; in_mplier = 8'h34; in_sign_mode = 2'b00; in_tag = 4'h5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(n, starts);
        total++;
        if (n !== LAT || out_product !== exp_p || out_tag !== 4'h5) begin
            bad++;
            $display("FAIL bp_first: cycles=%0d product=%h tag=%h expected %0d %h 5", n, out_product, out_tag, LAT, exp_p);
        end
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_mcand = 8'($urandom); in_mplier = 8'($urandom); in_tag = 4'($urandom);
            #1;
            if (in_ready !== 1'b0) errs++;
            tick();
            if (out_valid !== 1'b1 || out_product !== exp_p || out_tag !== 4'h5 || core_start !== 1'b0) errs++;
        end
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable cycles expected 0", errs);
        end
        in_mcand = 8'd7; in_mplier = 8'd9; in_sign_mode = 2'b00; in_tag = 4'hA; in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready_follow: in_ready=%b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || core_start !== 1'b1) begin
            bad++;
            $display("FAIL bp_retire_accept: valid=%b start=%b expected 0 1", out_valid, core_start);
        end
        wait_result(n, starts);
        total++;
        if (n !== LAT || out_product !== 16'h003F || out_tag !== 4'hA) begin
            bad++;
            $display("FAIL bp_second: cycles=%0d product=%h tag=%h expected %0d 003f a", n, out_product, out_tag, LAT);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ra[3] = '{8'h01, 8'h80, 8'h7F};
        logic [7:0] rb[3] = '{8'h01, 8'h80, 8'h81};
        logic [1:0] rm[3] = '{2'b00, 2'b11, 2'b11};
        int n, starts;
        out_ready = 1'b1;
        in_mcand = ra[0]; in_mplier = rb[0]; in_sign_mode = rm[0]; in_tag = 4'h1; in_valid = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) begin
                in_mcand = ra[k+1]; in_mplier = rb[k+1]; in_sign_mode = rm[k+1]; in_tag = 4'(k + 2);
            end else begin
                in_valid = 1'b0;
            end
            wait_result(n, starts);
            total++;
            if (n !== LAT || starts !== 1) begin
                bad++;
                $display("FAIL b2b_latency[%0d]: cycles=%0d starts=%0d expected %0d and 1", k, n, starts, LAT);
            end
            total++;
            if (out_product !== ref_mul(ra[k], rb[k], rm[k]) || out_tag !== 4'(k + 1)) begin
                bad++;
                $display("FAIL b2b_result[%0d]: product=%h tag=%h expected %h %h", k, out_product, out_tag,
                         ref_mul(ra[k], rb[k], rm[k]), 4'(k + 1));
            end
            tick();
            total++;
            if (out_valid !== 1'b0 || core_start !== (k < 2)) begin
                bad++;
                $display("FAIL b2b_handover[%0d]: valid=%b start=%b expected 0 %b", k, out_valid, core_start, k < 2);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        out_ready = 1'b1;
        in_mcand = 8'h55; in_mplier = 8'h0F; in_sign_mode = 2'b00; in_tag = 4'h9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || core_start !== 1'b0) begin
            bad++;
            $display("FAIL midreset_state: valid=%b ready=%b start=%b expected 0 1 0", out_valid, in_ready, core_start);
        end
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0 || core_start !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midreset_ignore_done: %0d disturbed cycles expected 0", seen);
        end
    endtask

`ifdef BOOTH_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        int n, starts;
        out_ready = 1'b1;
        done_en = 1'b0;
        in_mcand = 8'h21; in_mplier = 8'h43; in_sign_mode = 2'b01; in_tag = 4'hC; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(n, starts);
        total++;
        if (n !== TIMEOUT_CYC + 1) begin
            bad++;
            $display("FAIL timeout_latency: cycles=%0d expected %0d", n, TIMEOUT_CYC + 1);
        end
        total++;
        if (out_err !== 1'b1 || out_product !== 16'h0000 || out_tag !== 4'hC) begin
            bad++;
            $display("FAIL timeout_result: err=%b product=%h tag=%h expected 1 0000 c", out_err, out_product, out_tag);
        end
        tick();
        done_en = 1'b1;
        total++;
        if (out_err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_retire: err=%b valid=%b expected 0 0", out_err, out_valid);
        end
        in_mcand = 8'h06; in_mplier = 8'h07; in_sign_mode = 2'b00; in_tag = 4'hD; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_result(n, starts);
        total++;
        if (n !== LAT || out_err !== 1'b0 || out_product !== 16'd42 || out_tag !== 4'hD) begin
            bad++;
            $display("FAIL timeout_recover: cycles=%0d err=%b product=%h tag=%h expected %0d 0 002a d",
                     n, out_err, out_product, out_tag, LAT);
        end
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_mcand = '0;
        in_mplier = '0;
        in_sign_mode = '0;
        in_tag = '0;
        out_ready = 1'b1;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef BOOTH_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
